// File: rtl/keypad_matrix_emulator.sv
// keypad_matrix_emulator: 4x4 keypad responder with press/hold/release timing; KEYPAD_EMU_BOUNCE_EN adds contact bounce
module keypad_matrix_emulator #(
  parameter int HOLD_CYCLES    = 5400,
  parameter int GAP_CYCLES     = 540,
  parameter int BOUNCE_PERIOD  = 8,
  parameter int BOUNCE_TOGGLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] key_code,
  input  logic       press_req,
  output logic       busy,
  output logic       done,
  input  logic [3:0] columna_i,
  output logic [3:0] key_out
);
  localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ?
                        ((HOLD_CYCLES > BOUNCE_PERIOD) ? HOLD_CYCLES : BOUNCE_PERIOD) :
                        ((GAP_CYCLES > BOUNCE_PERIOD) ? GAP_CYCLES : BOUNCE_PERIOD);
  localparam int CW = $clog2(MAXC + 1);
  typedef enum logic [2:0] {IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT, GAP} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] row_q, col_q;
  logic contact_q, contact_d, done_d, latch;
`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam int PW = $clog2(BOUNCE_TOGGLES + 1);
  logic [PW-1:0] phase_q, phase_d;
  logic last_phase;
  assign last_phase = phase_q == PW'(BOUNCE_TOGGLES - 1);
  // bounce phase counter, restarted on entry to each bounce state
  always_ff @(posedge clk or posedge reset)
    if (reset) phase_q <= '0;
    else phase_q <= phase_d;
`endif
  // state, timing counter, latched key, contact and done pulse
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      row_q     <= '0;
      col_q     <= '0;
      contact_q <= 1'b0;
      done_q_reg: done <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      contact_q <= contact_d;
      done      <= done_d;
      if (latch) {row_q, col_q} <= key_code;
    end
  // next-state: each state counts its down-counter to zero, reloading on entry to the next
  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - CW'(1);
    done_d  = 1'b0;
    latch   = 1'b0;
`ifdef KEYPAD_EMU_BOUNCE_EN
    phase_d = phase_q;
`endif
    case (state_q)
      IDLE: if (press_req) begin
        latch = 1'b1;
`ifdef KEYPAD_EMU_BOUNCE_EN
        state_d = BOUNCE_IN;
        cnt_d   = CW'(BOUNCE_PERIOD - 1);
        phase_d = '0;
`else
        state_d = HOLD;
        cnt_d   = CW'(HOLD_CYCLES - 1);
`endif
      end
`ifdef KEYPAD_EMU_BOUNCE_EN
      BOUNCE_IN: if (cnt_q == '0) begin
        state_d = last_phase ? HOLD : BOUNCE_IN;
        cnt_d   = last_phase ? CW'(HOLD_CYCLES - 1) : CW'(BOUNCE_PERIOD - 1);
        phase_d = phase_q + PW'(1);
      end
      HOLD: if (cnt_q == '0) begin
        state_d = BOUNCE_OUT;
        cnt_d   = CW'(BOUNCE_PERIOD - 1);
        phase_d = '0;
      end
      BOUNCE_OUT: if (cnt_q == '0) begin
        state_d = last_phase ? GAP : BOUNCE_OUT;
        cnt_d   = last_phase ? CW'(GAP_CYCLES - 1) : CW'(BOUNCE_PERIOD - 1);
        phase_d = phase_q + PW'(1);
      end
`else
      HOLD: if (cnt_q == '0) begin
        state_d = GAP;
        cnt_d   = CW'(GAP_CYCLES - 1);
      end
`endif
      GAP: if (cnt_q == '0) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  // outputs: contact follows the upcoming state/phase so it closes the cycle after acceptance
  always_comb begin
`ifdef KEYPAD_EMU_BOUNCE_EN
    contact_d = (state_d == HOLD) | ((state_d == BOUNCE_IN) & ~phase_d[0]) |
                ((state_d == BOUNCE_OUT) & phase_d[0]);
`else
    contact_d = state_d == HOLD;
`endif
    busy = state_q != IDLE;
    key_out = 4'b1111;
    key_out[row_q] = ~(contact_q & ~columna_i[col_q]);
  end
endmodule

// File: tb/tb_keypad_matrix_emulator.sv
// tb_keypad_matrix_emulator: directed table-driven bench for keypad_matrix_emulator
module tb_keypad_matrix_emulator;
  localparam int HOLD = 10, GAP = 3, BP = 2, BT = 4;
`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam int BL = BP * BT;
`else
  localparam int BL = 0;
`endif
  localparam int TOT = 2 * BL + HOLD + GAP;
  logic clk = 0, reset = 1, press_req = 0, busy, done;
  logic [3:0] key_code = 0, columna_i = 4'b1111, key_out;
  int checks = 0, errors = 0;
  typedef struct {logic [3:0] code; logic [3:0] col; logic [3:0] exp;} vec_t;
  vec_t vecs [7];
  keypad_matrix_emulator #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .BOUNCE_PERIOD(BP), .BOUNCE_TOGGLES(BT)) dut (
    .clk(clk), .reset(reset), .key_code(key_code), .press_req(press_req),
    .busy(busy), .done(done), .columna_i(columna_i), .key_out(key_out));
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%b exp=%b t=%0t", nm, act, exp, $time);
    end
  endtask
  function automatic bit exp_contact(input int k);
    if (k <= BL) return ((k - 1) / BP) % 2 == 0;
    k -= BL;
    if (k <= HOLD) return 1;
    k -= HOLD;
    if (k <= BL) return ((k - 1) / BP) % 2 == 1;
    return 0;
  endfunction
  task automatic run_vec(input vec_t v, input int idx);
    key_code = v.code; columna_i = v.col; press_req = 1;
    step;
    press_req = 0;
    for (int k = 1; k <= TOT + 1; k++) begin
      chk($sformatf("v%0d_key_c%0d", idx, k), key_out, exp_contact(k) ? v.exp : 4'b1111);
      chk($sformatf("v%0d_busy_c%0d", idx, k), {3'b0, busy}, {3'b0, k <= TOT});
      chk($sformatf("v%0d_done_c%0d", idx, k), {3'b0, done}, {3'b0, k == TOT + 1});
      step;
    end
    chk($sformatf("v%0d_done_width", idx), {3'b0, done}, 4'd0);
  endtask
  initial begin
    int dcount;
    vecs[0] = '{4'b0110, 4'b1011, 4'b1101};
    vecs[1] = '{4'b0110, 4'b1110, 4'b1111};
    vecs[2] = '{4'b0000, 4'b1110, 4'b1110};
    vecs[3] = '{4'b1111, 4'b0111, 4'b0111};
    vecs[4] = '{4'b1001, 4'b1101, 4'b1011};
    vecs[5] = '{4'b0111, 4'b0000, 4'b1101};
    vecs[6] = '{4'b1000, 4'b1101, 4'b1111};
    columna_i = 4'b1110;
    #2;
    chk("rst_key", key_out, 4'b1111);
    chk("rst_busy", {3'b0, busy}, 4'd0);
    chk("rst_done", {3'b0, done}, 4'd0);
    step; step;
    reset = 0;
    step;
    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);
    // async reset mid-hold
    key_code = 4'b0000; columna_i = 4'b1110; press_req = 1;
    step;
    press_req = 0;
    repeat (BL + 5) step;
    chk("pre_rst_key", key_out, 4'b1110);
    #2 reset = 1;
    #1;
    chk("async_rst_key", key_out, 4'b1111);
    chk("async_rst_busy", {3'b0, busy}, 4'd0);
    step;
    reset = 0;
    dcount = 0;
    repeat (TOT + 5) begin
      step;
      if (done) dcount++;
    end
    chk("rst_no_done", 4'(dcount), 4'd0);
    chk("rst_idle_key", key_out, 4'b1111);
    // press while busy is ignored
    key_code = 4'b0110; columna_i = 4'b1011; press_req = 1;
    step;
    press_req = 0;
    repeat (BL + 4) step;
    key_code = 4'hF; press_req = 1;
    step;
    press_req = 0;
    chk("rej_busy", {3'b0, busy}, 4'd1);
    chk("rej_key", key_out, 4'b1101);
    columna_i = 4'b0111;
    #1;
    chk("rej_col3", key_out, 4'b1111);
    columna_i = 4'b1011;
    dcount = 0;
    repeat (TOT + 10) begin
      step;
      if (done) dcount++;
    end
    chk("rej_one_done", 4'(dcount), 4'd1);
    chk("rej_idle_busy", {3'b0, busy}, 4'd0);
    // back-to-back with press_req held
    key_code = 4'b0110; press_req = 1;
    step;
    for (int k = 1; k <= 2 * (TOT + 1); k++) begin
      if (k == 2 * (TOT + 1)) press_req = 0;
      chk($sformatf("b2b_done_c%0d", k), {3'b0, done}, {3'b0, k == TOT + 1 || k == 2 * (TOT + 1)});
      chk($sformatf("b2b_busy_c%0d", k), {3'b0, busy}, {3'b0, !(k == TOT + 1 || k == 2 * (TOT + 1))});
      step;
    end
    chk("b2b_end_busy", {3'b0, busy}, 4'd0);
    chk("b2b_end_done", {3'b0, done}, 4'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
